alu_unit: RTL and testbench



---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_if.sv | 33 +++
 rtl/alu_addsub.sv | 19 +
 rtl/alu_unit.sv | 59 +++++
 tb/tb_alu_unit.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the registered add/subtract unit.
// Flag indices describe the packed flag register used when ALU_FLAGS_EN is defined.
package alu_pkg;
   localparam logic ALU_OP_ADD = 1'b0;
   localparam logic ALU_OP_SUB = 1'b1;

   localparam int ALU_WIDTH_DEFAULT = 16;

   localparam int FLAG_Z = 0;
   localparam int FLAG_C = 1;
   localparam int FLAG_N = 2;
   localparam int FLAG_V = 3;
   localparam int FLAG_W = 4;
endpackage

// File: rtl/alu_if.sv
// Operand/result bundle for alu_unit; the flag signals exist only when ALU_FLAGS_EN is defined.
interface alu_if
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH_DEFAULT
);
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] out;
`ifdef ALU_FLAGS_EN
   logic             flag_z;
   logic             flag_c;
   logic             flag_n;
   logic             flag_v;
`endif

   modport master (
      output op, a, b,
      input  out
`ifdef ALU_FLAGS_EN
      , input flag_z, flag_c, flag_n, flag_v
`endif
   );

   modport slave (
      input  op, a, b,
      output out
`ifdef ALU_FLAGS_EN
      , output flag_z, flag_c, flag_n, flag_v
`endif
   );
endinterface

// File: rtl/alu_addsub.sv
// Combinational (WIDTH+1)-bit adder; subtract is a + ~b + 1 via carry-in = op.
module alu_addsub
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   full;

   assign b_eff = (op == ALU_OP_SUB) ? ~b : b;
   assign full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op};
   assign {carry, sum} = full;
endmodule

// File: rtl/alu_unit.sv
// Registered add/subtract unit, one-cycle latency, throughput one op per clock.
// Define ALU_FLAGS_EN to add registered Z/C/N/V status flags.
module alu_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   alu_if.slave bus
);
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic [WIDTH-1:0] out_q;

   alu_addsub #(.WIDTH(WIDTH)) u_addsub (
      .op    (bus.op),
      .a     (bus.a),
      .b     (bus.b),
      .sum   (sum),
      .carry (carry)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) out_q <= '0;
      else        out_q <= sum;
   end

   assign bus.out = out_q;

`ifdef ALU_FLAGS_EN
   logic [FLAG_W-1:0] flags_d;
   logic [FLAG_W-1:0] flags_q;
   logic              b_eff_msb;

   // Overflow: operands agree in sign but the result does not.
   always_comb begin
      flags_d         = '0;
      b_eff_msb       = bus.op ? ~bus.b[WIDTH-1] : bus.b[WIDTH-1];
      flags_d[FLAG_Z] = (sum == '0);
      flags_d[FLAG_C] = carry;
      flags_d[FLAG_N] = sum[WIDTH-1];
      flags_d[FLAG_V] = (bus.a[WIDTH-1] == b_eff_msb) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) flags_q <= '0;
      else        flags_q <= flags_d;
   end

   assign bus.flag_z = flags_q[FLAG_Z];
   assign bus.flag_c = flags_q[FLAG_C];
   assign bus.flag_n = flags_q[FLAG_N];
   assign bus.flag_v = flags_q[FLAG_V];
`else
   logic unused_carry;
   assign unused_carry = carry;
`endif
endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit at WIDTH=16 and WIDTH=8; flag checks compile in with ALU_FLAGS_EN.
module tb_alu_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   alu_if #(.WIDTH(16)) bus16 ();
   alu_if #(.WIDTH(8))  bus8 ();

   alu_unit #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
   alu_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

   always #5 clk = ~clk;

   // Reference: plain integer arithmetic modulo 2^w.
   function automatic int ref_res(int w, bit op, int a, int b);
      int m;
      m = 1 << w;
      return op ? ((a - b + m) % m) : ((a + b) % m);
   endfunction

`ifdef ALU_FLAGS_EN
   // Packed as {z, c, n, v}; v from true signed arithmetic range check.
   function automatic logic [3:0] ref_flags(int w, bit op, int a, int b);
      int m, half, r, sa, sb, sr;
      logic z, c, n, v;
      m    = 1 << w;
      half = 1 << (w - 1);
      r    = ref_res(w, op, a, b);
      sa   = (a >= half) ? a - m : a;
      sb   = (b >= half) ? b - m : b;
      sr   = op ? sa - sb : sa + sb;
      z    = (r == 0);
      c    = op ? (a >= b) : ((a + b) >= m);
      n    = (r >= half);
      v    = (sr < -half) || (sr >= half);
      return {z, c, n, v};
   endfunction
`endif

   task automatic drive16(bit op, int a, int b);
      @(negedge clk);
      bus16.op = op;
      bus16.a  = a[15:0];
      bus16.b  = b[15:0];
   endtask

   task automatic drive8(bit op, int a, int b);
      @(negedge clk);
      bus8.op = op;
      bus8.a  = a[7:0];
      bus8.b  = b[7:0];
   endtask

   task automatic test_reset();
      @(negedge clk);
      bus16.op = 1'b0; bus16.a = 16'h1234; bus16.b = 16'h0101;
      bus8.op  = 1'b0; bus8.a  = 8'h12;    bus8.b  = 8'h01;
      @(posedge clk); #1;
      total++;
      if (bus16.out !== 16'h0000) begin
         bad++; $display("FAIL reset_out16 got=%h want=0000", bus16.out);
      end
      total++;
      if (bus8.out !== 8'h00) begin
         bad++; $display("FAIL reset_out8 got=%h want=00", bus8.out);
      end
`ifdef ALU_FLAGS_EN
      total++;
      if ({bus16.flag_z, bus16.flag_c, bus16.flag_n, bus16.flag_v} !== 4'b0000) begin
         bad++; $display("FAIL reset_flags16 got=%b want=0000",
                         {bus16.flag_z, bus16.flag_c, bus16.flag_n, bus16.flag_v});
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      bit ops[6]  = '{1'b0,  1'b1,  1'b0,    1'b0,    1'b1,    1'b1};
      int as[6]   = '{'h39,  'h39,  'hFFFF,  'h7FFF,  'h0000,  'h8000};
      int bs[6]   = '{'h30,  'h30,  'h0001,  'h0001,  'h0001,  'h0001};
      int exp;
      for (int i = 0; i < 6; i++) begin
         drive16(ops[i], as[i], bs[i]);
         @(posedge clk); #1;
         exp = ref_res(16, ops[i], as[i], bs[i]);
         total++;
         if (bus16.out !== exp[15:0]) begin
            bad++; $display("FAIL directed_out[%0d] got=%h want=%h", i, bus16.out, exp[15:0]);
         end
`ifdef ALU_FLAGS_EN
         total++;
         if ({bus16.flag_z, bus16.flag_c, bus16.flag_n, bus16.flag_v} !== ref_flags(16, ops[i], as[i], bs[i])) begin
            bad++; $display("FAIL directed_flags[%0d] got=%b want=%b", i,
                            {bus16.flag_z, bus16.flag_c, bus16.flag_n, bus16.flag_v},
                            ref_flags(16, ops[i], as[i], bs[i]));
         end
`endif
      end
   endtask

   task automatic test_async_reset();
      drive16(1'b0, 'h39, 'h30);
      @(posedge clk); #1;
      total++;
      if (bus16.out !== 16'h0069) begin
         bad++; $display("FAIL arst_pre got=%h want=0069", bus16.out);
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (bus16.out !== 16'h0000) begin
         bad++; $display("FAIL arst_immediate got=%h want=0000", bus16.out);
      end
`ifdef ALU_FLAGS_EN
      total++;
      if ({bus16.flag_z, bus16.flag_c, bus16.flag_n, bus16.flag_v} !== 4'b0000) begin
         bad++; $display("FAIL arst_flags got=%b want=0000",
                         {bus16.flag_z, bus16.flag_c, bus16.flag_n, bus16.flag_v});
      end
`endif
      drive16(1'b0, 'h0002, 'h0003);
      @(posedge clk); #1;
      total++;
      if (bus16.out !== 16'h0000) begin
         bad++; $display("FAIL arst_held got=%h want=0000", bus16.out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      total++;
      if (bus16.out !== 16'h0005) begin
         bad++; $display("FAIL arst_first_result got=%h want=0005", bus16.out);
      end
   endtask

   task automatic test_back_to_back();
      int prev;
      int exp;
      bit op;
      prev = ref_res(16, 1'b0, 'h0002, 'h0003);
      for (int i = 0; i < 8; i++) begin
         op = i[0];
         drive16(op, 'h39, 'h30);
         #1;
         total++;
         if (bus16.out !== prev[15:0]) begin
            bad++; $display("FAIL b2b_hold[%0d] got=%h want=%h", i, bus16.out, prev[15:0]);
         end
         @(posedge clk); #1;
         exp = ref_res(16, op, 'h39, 'h30);
         total++;
         if (bus16.out !== exp[15:0]) begin
            bad++; $display("FAIL b2b_out[%0d] got=%h want=%h", i, bus16.out, exp[15:0]);
         end
         prev = exp;
      end
   endtask

   task automatic test_random16();
      int a, b, exp;
      bit op;
      for (int i = 0; i < 60; i++) begin
         a  = int'($urandom_range(0, 'hFFFF));
         b  = int'($urandom_range(0, 'hFFFF));
         op = 1'($urandom_range(0, 1));
         if (i < 4) begin
            a = (i < 2) ? 'h8000 : 'hFFFF;
            b = (i[0]) ? 'h8000 : 'hFFFF;
         end
         drive16(op, a, b);
         @(posedge clk); #1;
         exp = ref_res(16, op, a, b);
         total++;
         if (bus16.out !== exp[15:0]) begin
            bad++; $display("FAIL rand16_out[%0d] op=%0d a=%h b=%h got=%h want=%h",
                            i, op, a[15:0], b[15:0], bus16.out, exp[15:0]);
         end
`ifdef ALU_FLAGS_EN
         total++;
         if ({bus16.flag_z, bus16.flag_c, bus16.flag_n, bus16.flag_v} !== ref_flags(16, op, a, b)) begin
            bad++; $display("FAIL rand16_flags[%0d] op=%0d a=%h b=%h got=%b want=%b",
                            i, op, a[15:0], b[15:0],
                            {bus16.flag_z, bus16.flag_c, bus16.flag_n, bus16.flag_v},
                            ref_flags(16, op, a, b));
         end
`endif
      end
   endtask

   task automatic test_width8();
      int a, b, exp;
      bit op;
      for (int i = 0; i < 40; i++) begin
         a  = int'($urandom_range(0, 'hFF));
         b  = int'($urandom_range(0, 'hFF));
         op = 1'($urandom_range(0, 1));
         if (i == 0) begin a = 'hFF; b = 'h01; op = 1'b0; end
         if (i == 1) begin a = 'h00; b = 'h01; op = 1'b1; end
         if (i == 2) begin a = 'h7F; b = 'h01; op = 1'b0; end
         drive8(op, a, b);
         @(posedge clk); #1;
         exp = ref_res(8, op, a, b);
         total++;
         if (bus8.out !== exp[7:0]) begin
            bad++; $display("FAIL w8_out[%0d] op=%0d a=%h b=%h got=%h want=%h",
                            i, op, a[7:0], b[7:0], bus8.out, exp[7:0]);
         end
`ifdef ALU_FLAGS_EN
         total++;
         if ({bus8.flag_z, bus8.flag_c, bus8.flag_n, bus8.flag_v} !== ref_flags(8, op, a, b)) begin
            bad++; $display("FAIL w8_flags[%0d] op=%0d a=%h b=%h got=%b want=%b",
                            i, op, a[7:0], b[7:0],
                            {bus8.flag_z, bus8.flag_c, bus8.flag_n, bus8.flag_v},
                            ref_flags(8, op, a, b));
         end
`endif
      end
   endtask

   initial begin
      bus16.op = 1'b0; bus16.a = '0; bus16.b = '0;
      bus8.op  = 1'b0; bus8.a  = '0; bus8.b  = '0;
      test_reset();
      test_directed();
      test_async_reset();
      test_back_to_back();
      test_random16();
      test_width8();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
